// File: rtl/bus_driver_arb_if.sv
// rtl/bus_driver_arb_if.sv - request/grant signal bundle for the shared-bus arbiter
// The tri-state bus itself stays a plain port so it can resolve as a real net.
interface bus_driver_arb_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int OWNER_W  = 1
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic [CHANNELS-1:0]       enb_n;
  logic [OWNER_W-1:0]        owner;
  logic                      busy;
  logic                      pending;
  logic                      dout_oe;

  modport master (output din, output enb_n,
                  input owner, input busy, input pending, input dout_oe);
  modport slave  (input din, input enb_n,
                  output owner, output busy, output pending, output dout_oe);
endinterface

// File: rtl/bus_driver_arb.sv
// rtl/bus_driver_arb.sv - arbitrated tri-state bus driver with registered data
// and a forced high-Z turnaround gap between successive owners.
module bus_driver_arb #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 2,
  parameter int OWNER_W    = 1,
  parameter int INVERT     = 1,
  parameter int TURNAROUND = 1
) (
  input  logic             clk,
  input  logic             reset,
  bus_driver_arb_if.slave  bus,
  output wire [WIDTH-1:0]  dout
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;
  localparam logic [3:0] TA_LOAD = 4'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);

  logic [1:0]         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [3:0]         tcnt_q, tcnt_d;
  logic [OWNER_W-1:0] req_idx;
  logic               any_req;
  logic               pending_c;

  // Scan downward so the lowest requesting channel is the one left standing.
  always_comb begin
    req_idx = '0;
    any_req = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (!bus.enb_n[i]) begin
        req_idx = OWNER_W'(i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    pending_c = 1'b0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (OWNER_W'(j) != owner_q && !bus.enb_n[j]) pending_c = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    data_d  = data_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = req_idx;
          data_d  = bus.din[req_idx*WIDTH +: WIDTH];
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (!bus.enb_n[owner_q]) begin
          data_d = bus.din[owner_q*WIDTH +: WIDTH];
        end else if (TURNAROUND > 0) begin
          state_d = S_TURN;
          tcnt_d  = TA_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        if (tcnt_q == 4'd0) state_d = S_IDLE;
        else                tcnt_d  = tcnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      data_q  <= '0;
      tcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign bus.owner   = owner_q;
  assign bus.busy    = (state_q == S_DRIVE);
  assign bus.pending = pending_c;
  assign bus.dout_oe = (state_q == S_DRIVE);

  assign dout = (state_q == S_DRIVE) ? ((INVERT != 0) ? ~data_q : data_q)
                                     : {WIDTH{1'bz}};
endmodule

// File: tb/tb_bus_driver_arb.sv
// tb/tb_bus_driver_arb.sv - three arbiter configurations checked against a
// cycle-level ownership/gap model plus directed literal expectations.
module tb_bus_driver_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit started = 1'b0;

  logic [3:0] enb [3];
  logic [7:0] dd  [3][4];

  int p_nch [3] = '{2, 2, 4};
  int p_inv [3] = '{1, 0, 1};
  int p_ta  [3] = '{1, 0, 3};

  bit         m_drv [3];
  int         m_gap [3];
  int         m_own [3];
  logic [7:0] m_dq  [3];

  bus_driver_arb_if #(.WIDTH(8), .CHANNELS(2), .OWNER_W(1)) if0 ();
  bus_driver_arb_if #(.WIDTH(8), .CHANNELS(2), .OWNER_W(1)) if1 ();
  bus_driver_arb_if #(.WIDTH(8), .CHANNELS(4), .OWNER_W(2)) if2 ();
  wire [7:0] dout0, dout1, dout2;

  assign if0.din   = {dd[0][1], dd[0][0]};
  assign if0.enb_n = enb[0][1:0];
  assign if1.din   = {dd[1][1], dd[1][0]};
  assign if1.enb_n = enb[1][1:0];
  assign if2.din   = {dd[2][3], dd[2][2], dd[2][1], dd[2][0]};
  assign if2.enb_n = enb[2];

  bus_driver_arb #(.WIDTH(8), .CHANNELS(2), .OWNER_W(1), .INVERT(1), .TURNAROUND(1))
    dut0 (.clk(clk), .reset(reset), .bus(if0.slave), .dout(dout0));
  bus_driver_arb #(.WIDTH(8), .CHANNELS(2), .OWNER_W(1), .INVERT(0), .TURNAROUND(0))
    dut1 (.clk(clk), .reset(reset), .bus(if1.slave), .dout(dout1));
  bus_driver_arb #(.WIDTH(8), .CHANNELS(4), .OWNER_W(2), .INVERT(1), .TURNAROUND(3))
    dut2 (.clk(clk), .reset(reset), .bus(if2.slave), .dout(dout2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: an owner drives until it drops its request, then the bus stays
  // dark for a fixed number of cycles, then one idle cycle may grant again.
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_drv[k] = 1'b0; m_gap[k] = 0; m_own[k] = 0; m_dq[k] = 8'h00;
      end else if (m_drv[k]) begin
        if (!enb[k][m_own[k]]) m_dq[k] = dd[k][m_own[k]];
        else begin m_drv[k] = 1'b0; m_gap[k] = p_ta[k]; end
      end else if (m_gap[k] > 0) begin
        m_gap[k]--;
      end else begin
        for (int i = p_nch[k] - 1; i >= 0; i--) begin
          if (!enb[k][i]) begin
            m_own[k] = i; m_dq[k] = dd[k][i]; m_drv[k] = 1'b1;
          end
        end
      end
    end
    started = 1'b1;
  end

  task automatic cmp_dut(input int k, input logic oe, input logic bsy,
                         input logic [1:0] own, input logic pnd, input logic [7:0] d);
    bit exp_pnd = 1'b0;
    logic [7:0] exp_d;
    for (int j = 0; j < p_nch[k]; j++)
      if (j != m_own[k] && !enb[k][j]) exp_pnd = 1'b1;
    exp_d = (p_inv[k] != 0) ? ~m_dq[k] : m_dq[k];
    chk($sformatf("m%0d_oe", k), {31'd0, oe}, {31'd0, m_drv[k]});
    chk($sformatf("m%0d_busy", k), {31'd0, bsy}, {31'd0, m_drv[k]});
    chk($sformatf("m%0d_owner", k), {30'd0, own}, m_own[k]);
    chk($sformatf("m%0d_pending", k), {31'd0, pnd}, {31'd0, exp_pnd});
    if (m_drv[k] && oe) chk($sformatf("m%0d_dout", k), {24'd0, d}, {24'd0, exp_d});
  endtask

  initial forever begin
    @(negedge clk);
    if (started) begin
      cmp_dut(0, if0.dout_oe, if0.busy, {1'b0, if0.owner}, if0.pending, dout0);
      cmp_dut(1, if1.dout_oe, if1.busy, {1'b0, if1.owner}, if1.pending, dout1);
      cmp_dut(2, if2.dout_oe, if2.busy, if2.owner, if2.pending, dout2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      enb[k] = 4'b1111;
      for (int c = 0; c < 4; c++) dd[k][c] = 8'h00;
    end
    tick(); tick();
    reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_oe", {31'd0, if0.dout_oe}, 0);
      chk("idle_busy", {31'd0, if0.busy}, 0);
      chk("idle_owner", {31'd0, if0.owner}, 0);
      chk("idle_pending", {31'd0, if0.pending}, 0);
    end

    dd[0][0] = 8'hA5; enb[0] = 4'b1110;
    tick();
    chk("t2_busy", {31'd0, if0.busy}, 1);
    chk("t2_owner", {31'd0, if0.owner}, 0);
    chk("t2_dout", {24'd0, dout0}, 32'h5A);
    dd[0][0] = 8'h0F;
    tick();
    chk("t2_dout_upd", {24'd0, dout0}, 32'hF0);

    enb[0] = 4'b1111;
    tick(); chk("t3_rel_turn", {31'd0, if0.dout_oe}, 0);
    tick(); chk("t3_rel_idle", {31'd0, if0.dout_oe}, 0);
    dd[0][1] = 8'h96; enb[0] = 4'b1100;
    tick();
    chk("t3_owner0", {31'd0, if0.owner}, 0);
    chk("t3_pending", {31'd0, if0.pending}, 1);
    chk("t3_dout0", {24'd0, dout0}, 32'hF0);
    enb[0] = 4'b1101;
    tick(); chk("t3_turn_oe", {31'd0, if0.dout_oe}, 0); chk("t3_turn_busy", {31'd0, if0.busy}, 0);
    tick(); chk("t3_idle_oe", {31'd0, if0.dout_oe}, 0); chk("t3_idle_owner", {31'd0, if0.owner}, 0);
    tick();
    chk("t3_owner1", {31'd0, if0.owner}, 1);
    chk("t3_dout1", {24'd0, dout0}, 32'h69);
    chk("t3_pending1", {31'd0, if0.pending}, 0);

    dd[1][1] = 8'h3C; enb[1] = 4'b1101;
    tick(); chk("t4_dout_ch1", {24'd0, dout1}, 32'h3C);
    enb[1] = 4'b1111;
    tick(); chk("t4_idle_oe", {31'd0, if1.dout_oe}, 0);
    dd[1][0] = 8'hC3; enb[1] = 4'b1110;
    tick();
    chk("t4_dout_ch0", {24'd0, dout1}, 32'hC3);
    chk("t4_owner", {31'd0, if1.owner}, 0);

    dd[2][2] = 8'h11; dd[2][3] = 8'h22; enb[2] = 4'b0011;
    tick();
    chk("t6_owner2", {30'd0, if2.owner}, 2);
    chk("t6_dout2", {24'd0, dout2}, 32'hEE);
    chk("t6_pending", {31'd0, if2.pending}, 1);
    enb[2] = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t6_gap%0d_oe", c), {31'd0, if2.dout_oe}, 0);
      chk($sformatf("t6_gap%0d_busy", c), {31'd0, if2.busy}, 0);
    end
    tick();
    chk("t6_owner3", {30'd0, if2.owner}, 3);
    chk("t6_busy3", {31'd0, if2.busy}, 1);
    chk("t6_dout3", {24'd0, dout2}, 32'hDD);

    reset = 1'b1;
    tick();
    chk("t5_oe", {31'd0, if0.dout_oe}, 0);
    chk("t5_owner", {31'd0, if0.owner}, 0);
    chk("t5_busy", {31'd0, if0.busy}, 0);
    chk("t5_pending", {31'd0, if0.pending}, 1);
    reset = 1'b0;
    tick();
    chk("t5_regrant_busy", {31'd0, if0.busy}, 1);
    chk("t5_regrant_owner", {31'd0, if0.owner}, 1);

    for (int k = 0; k < 3; k++) enb[k] = 4'b1111;
    for (int c = 0; c < 8; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
